i2s_bridge: RTL and testbench

I2S_BRIDGE -- requirements
Module: i2s_bridge

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_sync_edge.sv | 31 +++
 rtl/i2s_bridge.sv | 182 ++++++++++++++++++
 tb/tb_i2s_bridge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S bridge: channel encoding, receive
// sequencing states, default word/slot sizes and attenuation control width.
package i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_WAIT = 2'd1,
        RX_RUN  = 2'd2
    } rx_state_t;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_SLOT_WIDTH = 32;
    localparam int ATTEN_WIDTH    = 4;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with single-clk
// rise/fall strobes taken from the last two synchronised samples.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/i2s_bridge.sv
// I2S receive/retransmit bridge with per-channel holding registers and slot
// length checking. Optional attenuation port enabled by I2S_BRIDGE_ATTEN_EN.
//
// state   | meaning
// RX_IDLE | after reset, first bck rise records the current lrck level
// RX_WAIT | partial data ignored until lrck changes into a left slot
// RX_RUN  | words captured, slot lengths checked
module i2s_bridge
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SLOT_WIDTH  = DEF_SLOT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bck_in,
    input  logic                   lrck_in,
    input  logic                   data_in,
    output logic                   bck_out,
    output logic                   lrck_out,
    output logic                   data_out,
    output logic                   mclk_out,
    input  logic                   mute,
    input  logic                   err_clr,
`ifdef I2S_BRIDGE_ATTEN_EN
    input  logic [ATTEN_WIDTH-1:0] atten,
`endif
    output logic [DATA_WIDTH-1:0]  sample_l,
    output logic [DATA_WIDTH-1:0]  sample_r,
    output logic                   sample_valid,
    output logic                   frame_err
);

    localparam int CW = $clog2(SLOT_WIDTH + 2);
    localparam int TW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] DW_M1  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] SW_C   = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] SAT_C  = CW'(SLOT_WIDTH + 1);
    localparam logic [TW-1:0] TX_LEN = TW'(DATA_WIDTH);

    logic bck_s, bck_rise, bck_fall;
    logic lrck_s, lrck_rise_unused, lrck_fall_unused;
    logic [SYNC_STAGES-1:0] data_chain;
    logic data_s;

    assign mclk_out = clk;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bck_sync (
        .clk(clk), .rst_n(rst_n), .din(bck_in),
        .sync(bck_s), .rise(bck_rise), .fall(bck_fall)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk(clk), .rst_n(rst_n), .din(lrck_in),
        .sync(lrck_s), .rise(lrck_rise_unused), .fall(lrck_fall_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_chain <= '0;
        else        data_chain <= {data_chain[SYNC_STAGES-2:0], data_in};
    end
    assign data_s = data_chain[SYNC_STAGES-1];

    rx_state_t state, state_nxt;
    logic rx_primed, rx_run;
    logic lrck_prev_rx, lrck_chg;
    channel_t channel;
    logic [CW-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic word_done, short_err, long_err;

    assign lrck_chg = (lrck_s != lrck_prev_rx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE: if (bck_rise) state_nxt = RX_WAIT;
            RX_WAIT: if (bck_rise && lrck_chg && lrck_s == CH_LEFT) state_nxt = RX_RUN;
            RX_RUN:  state_nxt = RX_RUN;
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_primed = (state != RX_IDLE);
        rx_run    = (state == RX_RUN);
    end

    // The bit sampled on the lrck-change rise belongs to the previous slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev_rx <= 1'b0;
            channel      <= CH_LEFT;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            word_done    <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (bck_rise) begin
                lrck_prev_rx <= lrck_s;
                if (rx_primed && lrck_chg) begin
                    channel <= channel_t'(lrck_s);
                    bit_cnt <= '0;
                end else begin
                    if (bit_cnt < DW_C) rx_shift <= {rx_shift[DATA_WIDTH-2:0], data_s};
                    if (bit_cnt != SAT_C) bit_cnt <= bit_cnt + 1'b1;
                    word_done <= rx_run && (bit_cnt == DW_M1);
                end
            end
        end
    end

    assign short_err = bck_rise && rx_run && lrck_chg && (bit_cnt < DW_C);
    assign long_err  = bck_rise && rx_run && !lrck_chg && (bit_cnt == SW_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (word_done) begin
                if (channel == CH_LEFT) sample_l <= rx_shift;
                else                    sample_r <= rx_shift;
            end
            sample_valid <= word_done && (channel == CH_RIGHT);
            if (short_err || long_err) frame_err <= 1'b1;
            else if (err_clr)          frame_err <= 1'b0;
        end
    end

    logic [DATA_WIDTH-1:0] tx_sel, tx_word, tx_shift;
    logic [TW-1:0] tx_cnt;
    logic lrck_prev_tx;

    always_comb begin
        tx_sel = lrck_s ? sample_r : sample_l;
`ifdef I2S_BRIDGE_ATTEN_EN
        tx_word = DATA_WIDTH'($signed(tx_sel) >>> atten);
`else
        tx_word = tx_sel;
`endif
        if (mute) tx_word = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_out      <= 1'b0;
            lrck_out     <= 1'b0;
            data_out     <= 1'b0;
            lrck_prev_tx <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
        end else begin
            bck_out  <= bck_s;
            lrck_out <= lrck_s;
            if (bck_fall) begin
                lrck_prev_tx <= lrck_s;
                if (lrck_s != lrck_prev_tx) begin
                    tx_shift <= tx_word;
                    tx_cnt   <= '0;
                    data_out <= 1'b0;
                end else if (tx_cnt < TX_LEN) begin
                    data_out <= tx_shift[DATA_WIDTH-1];
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    tx_cnt   <= tx_cnt + 1'b1;
                end else begin
                    data_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_bridge.sv
// Scoreboard bench for i2s_bridge: directed I2S frames, decoupled monitors for
// captured samples and the retransmitted stream. Honours I2S_BRIDGE_ATTEN_EN.
`timescale 1ns/1ps
module tb_i2s_bridge;

    localparam int DW   = 24;
    localparam int HALF = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic bck_in = 1'b0, lrck_in = 1'b1, data_in = 1'b0;
    logic mute = 1'b0, err_clr = 1'b0;
`ifdef I2S_BRIDGE_ATTEN_EN
    logic [3:0] atten = 4'd0;
`endif
    logic bck_out, lrck_out, data_out, mclk_out, sample_valid, frame_err;
    logic [DW-1:0] sample_l, sample_r;

    always #5 clk = ~clk;

    i2s_bridge #(.DATA_WIDTH(DW), .SLOT_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .bck_in(bck_in), .lrck_in(lrck_in), .data_in(data_in),
        .bck_out(bck_out), .lrck_out(lrck_out), .data_out(data_out),
        .mclk_out(mclk_out), .mute(mute), .err_clr(err_clr),
`ifdef I2S_BRIDGE_ATTEN_EN
        .atten(atten),
`endif
        .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .frame_err(frame_err)
    );

    typedef struct packed { logic ch; logic [DW-1:0] word; } tx_exp_t;
    typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } smp_exp_t;

    tx_exp_t  tx_q[$];
    smp_exp_t smp_q[$];
    int checks = 0, failures = 0, tx_cmps = 0, smp_cmps = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_slot(input logic ch, input logic [DW-1:0] word,
                             input int first, input int last, input int dbits);
        for (int b = first; b < last; b++) begin
            repeat (HALF) @(posedge clk);
            #2;
            bck_in  = 1'b0;
            lrck_in = ch;
            data_in = (b >= 1 && b <= dbits) ? word[DW-b] : 1'b0;
            repeat (HALF) @(posedge clk);
            #2 bck_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input logic [DW-1:0] tl, input logic [DW-1:0] tr);
        smp_q.push_back('{l: l, r: r});
        tx_q.push_back('{ch: 1'b0, word: tl});
        send_slot(1'b0, l, 0, 32, DW);
        tx_q.push_back('{ch: 1'b1, word: tr});
        send_slot(1'b1, r, 0, 32, DW);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bck_out"}, 64'(bck_out), 64'd0);
        check({tag, "_lrck_out"}, 64'(lrck_out), 64'd0);
        check({tag, "_data_out"}, 64'(data_out), 64'd0);
        check({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_sample_l"}, 64'(sample_l), 64'd0);
        check({tag, "_sample_r"}, 64'(sample_r), 64'd0);
    endtask

    // Sample monitor: every sample_valid must match the oldest expected frame.
    initial begin
        smp_exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst_n && sample_valid) begin
                if (smp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample_valid actual=%0h_%0h required=none", sample_l, sample_r);
                end else begin
                    e = smp_q.pop_front();
                    smp_cmps++;
                    check("sample_lr", 64'({sample_l, sample_r}), 64'({e.l, e.r}));
                end
            end
        end
    end

    // Transmit monitor: rebuilds each lrck_out slot; bit 1 is the lrck-change bit,
    // bits 2..25 the word, the rest must be zero.
    initial begin
        logic pb, pl, armed, junk, slot_ch;
        int n;
        logic [DW-1:0] w;
        tx_exp_t cur;
        pb = 1'b0; pl = 1'b0; armed = 1'b0; junk = 1'b0; slot_ch = 1'b0; n = 0; w = '0;
        cur = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                armed = 1'b0; pb = 1'b0; pl = 1'b0;
                continue;
            end
            if (lrck_out != pl) begin
                if (armed) begin
                    tx_cmps++;
                    check("tx_slot", 64'({slot_ch, junk, w}), 64'({cur.ch, 1'b0, cur.word}));
                end
                armed = 1'b0;
                if (tx_q.size() > 0) begin
                    cur = tx_q.pop_front();
                    armed = 1'b1;
                end
                slot_ch = lrck_out; n = 0; w = '0; junk = 1'b0;
            end
            if (bck_out && !pb) begin
                n++;
                if (n >= 2 && n <= DW + 1) w = {w[DW-2:0], data_out};
                else if (data_out) junk = 1'b1;
            end
            pb = bck_out;
            pl = lrck_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 check_all_zero("reset");
        #1 rst_n = 1'b1;

        send_slot(1'b1, '0, 0, 32, 0);
        send_frame(24'h123456, 24'hABCDEF, 24'h000000, 24'h000000);
        send_frame(24'h000001, 24'h800000, 24'h123456, 24'hABCDEF);
        send_frame(24'h7FFFFF, 24'h00FF00, 24'h000001, 24'h800000);
        mute = 1'b1;
        send_frame(24'hA5A5A5, 24'h5A5A5A, 24'h000000, 24'h000000);
        mute = 1'b0;
        send_frame(24'h800000, 24'h400000, 24'hA5A5A5, 24'h5A5A5A);
`ifdef I2S_BRIDGE_ATTEN_EN
        atten = 4'd2;
        send_frame(24'h800000, 24'h123456, 24'hE00000, 24'h100000);
        atten = 4'd15;
        send_frame(24'h0F0F0F, 24'h000000, 24'hFFFFFF, 24'h000024);
        atten = 4'd0;
`else
        send_frame(24'h800000, 24'h123456, 24'h800000, 24'h400000);
        send_frame(24'h0F0F0F, 24'h000000, 24'h800000, 24'h123456);
`endif
        check("frame_err_normal", 64'(frame_err), 64'd0);

        // Short left slot: 16 bits then lrck toggles.
        smp_q.push_back('{l: 24'h0F0F0F, r: 24'h111111});
        send_slot(1'b0, 24'h999999, 0, 17, 16);
        send_slot(1'b1, 24'h111111, 0, 32, DW);
        check("frame_err_short", 64'(frame_err), 64'd1);
        check("sample_l_kept", 64'(sample_l), 64'h0F0F0F);
        pulse_clr();
        check("frame_err_clr1", 64'(frame_err), 64'd0);

        // Over-long left slot: 40 bits without an lrck change.
        smp_q.push_back('{l: 24'h222222, r: 24'h333333});
        send_slot(1'b0, 24'h222222, 0, 40, DW);
        check("frame_err_long", 64'(frame_err), 64'd1);
        send_slot(1'b1, 24'h333333, 0, 32, DW);
        pulse_clr();
        check("frame_err_clr2", 64'(frame_err), 64'd0);

        // Reset mid-left-slot; next right slot ignored, first full frame reported.
        send_slot(1'b0, 24'h777777, 0, 10, DW);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_all_zero("midreset");
        #1 rst_n = 1'b1;
        send_slot(1'b0, 24'h777777, 10, 32, DW);
        tx_q.push_back('{ch: 1'b1, word: 24'h000000});
        send_slot(1'b1, 24'h444444, 0, 32, DW);
        tx_q.push_back('{ch: 1'b0, word: 24'h000000});
        smp_q.push_back('{l: 24'h555555, r: 24'h666666});
        send_slot(1'b0, 24'h555555, 0, 32, DW);
        send_slot(1'b1, 24'h666666, 0, 32, DW);
        repeat (100) @(posedge clk);
        #1;
        check("frame_err_after_reset", 64'(frame_err), 64'd0);
        check("sample_l_final", 64'(sample_l), 64'h555555);
        check("sample_r_final", 64'(sample_r), 64'h666666);
        check("smp_compares", 64'(smp_cmps), 64'd10);
        check("tx_compares", 64'(tx_cmps), 64'd16);
        check("smp_q_left", 64'(smp_q.size()), 64'd0);
        check("tx_q_left", 64'(tx_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
